// File: rtl/acq_timing_manager.sv
// Divides the PWM-carrier qualifier into an acquisition trigger, timestamps the
// done edges of enabled sensor channels and raises a latched scheduler interrupt.
// Optional macro TIMING_MGR_TIMEOUT_EN adds window timeout, ch_missed and timeout_flag.
module acq_timing_manager #(
    parameter int NUM_CH  = 6,
    parameter int CNT_W   = 16,
    parameter int RATIO_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    event_qualifier,
    input  logic [RATIO_W-1:0]      user_ratio,
    input  logic [NUM_CH-1:0]       en_bits,
    input  logic [NUM_CH-1:0]       done,
    input  logic [CNT_W-1:0]        timeout_limit,
    input  logic                    reset_sched_isr,
    output logic                    trigger,
    output logic [NUM_CH-1:0]       en_out,
    output logic [NUM_CH*CNT_W-1:0] ch_time,
    output logic                    sched_isr,
    output logic                    busy,
    output logic [NUM_CH-1:0]       ch_missed,
    output logic                    timeout_flag,
    output logic                    overrun_flag
);
    typedef enum logic {IDLE = 1'b0, ACQ = 1'b1} state_t;

    state_t             r_state, w_state_next;
    logic [RATIO_W-1:0] r_count;
    logic               r_trigger;
    logic [NUM_CH-1:0]  r_done_ff;
    logic [NUM_CH-1:0]  r_en;
    logic [NUM_CH-1:0]  r_captured;
    logic [CNT_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_ch_time [NUM_CH];
    logic               r_isr;
    logic               r_overrun;
    logic               r_timeout;
    logic [NUM_CH-1:0]  r_missed;

    logic [NUM_CH-1:0]  w_new;
    logic [NUM_CH-1:0]  w_cov;
    logic               w_in_acq;
    logic               w_restart;
    logic               w_complete;
    logic               w_tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_trigger <= 1'b0;
        end else if (event_qualifier) begin
            if (r_count == user_ratio) begin
                r_count   <= '0;
                r_trigger <= 1'b1;
            end else begin
                r_count   <= r_count + 1'b1;
                r_trigger <= 1'b0;
            end
        end else begin
            r_trigger <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // A trigger always wins over completion/timeout in the same cycle: the window restarts.
    always_comb begin
        w_in_acq   = (r_state == ACQ);
        w_new      = done & ~r_done_ff & r_en & ~r_captured;
        w_cov      = r_captured | w_new;
        w_restart  = r_trigger && (w_in_acq || (en_bits != '0));
        w_complete = w_in_acq && !r_trigger && ((w_cov & r_en) == r_en);
`ifdef TIMING_MGR_TIMEOUT_EN
        w_tmo      = w_in_acq && !r_trigger && !w_complete &&
                     (timeout_limit != '0) && (r_timer == timeout_limit);
`else
        w_tmo      = 1'b0;
`endif
        w_state_next = r_state;
        if (r_trigger)
            w_state_next = (en_bits != '0) ? ACQ : IDLE;
        else if (w_complete || w_tmo)
            w_state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_ff  <= '0;
            r_en       <= '0;
            r_captured <= '0;
            r_timer    <= '0;
        end else begin
            r_done_ff <= done;
            if (w_restart) begin
                r_en       <= en_bits;
                r_captured <= '0;
                r_timer    <= '0;
            end else if (w_in_acq) begin
                r_captured <= w_cov;
                if (r_timer != '1) r_timer <= r_timer + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_ch_time[gi] <= '0;
                else if (w_in_acq && !r_trigger && w_new[gi])
                    r_ch_time[gi] <= r_timer;
            end
            assign ch_time[gi*CNT_W +: CNT_W] = r_ch_time[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_isr     <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
            r_missed  <= '0;
        end else begin
            if (w_complete || w_tmo) r_isr <= 1'b1;
            else if (reset_sched_isr) r_isr <= 1'b0;
            if (r_trigger && w_in_acq) r_overrun <= 1'b1;
            else if (reset_sched_isr)  r_overrun <= 1'b0;
            if (w_tmo) begin
                r_timeout <= 1'b1;
                r_missed  <= r_missed | (r_en & ~w_cov);
            end else if (reset_sched_isr) begin
                r_timeout <= 1'b0;
                r_missed  <= '0;
            end
        end
    end

`ifndef TIMING_MGR_TIMEOUT_EN
    logic w_unused_tlim;
    assign w_unused_tlim = ^timeout_limit;
`endif

    assign trigger      = r_trigger;
    assign en_out       = r_en;
    assign sched_isr    = r_isr;
    assign busy         = w_in_acq;
    assign overrun_flag = r_overrun;
    assign timeout_flag = r_timeout;
    assign ch_missed    = r_missed;
endmodule
